// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU and the two-requester arbiter in front of it.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: and / or / add / sub, results wrap modulo 2^8.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       ALUControl,
  output logic [ALU_W-1:0] ALUResult
);

  always_comb begin
    ALUResult = '0;
    case (alu_op_t'(ALUControl))
      ALU_AND: ALUResult = a & b;
      ALU_OR:  ALUResult = a | b;
      ALU_ADD: ALUResult = a + b;
      ALU_SUB: ALUResult = a - b;
      default: ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one alu between two valid/ready requesters,
// holding each registered result until its owner consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR_START = 0
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][ALU_W-1:0] req_a,
  input  logic [1:0][ALU_W-1:0] req_b,
  input  logic [1:0][1:0]       req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [ALU_W-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam logic RR_FIRST = (RR_START != 0);

  arb_state_t       state;
  arb_state_t       next_state;
  logic             last_grant;
  logic             gid;
  logic             pick;
  logic             accept;
  logic             consume;
  logic [ALU_W-1:0] op_a;
  logic [ALU_W-1:0] op_b;
  alu_op_t          op_code;
  logic [ALU_W-1:0] alu_result;

  // On contention the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (&req_valid) begin
      pick = ~last_grant;
    end else if (req_valid[1]) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    accept     = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[pick] = 1'b1;
          accept          = 1'b1;
          next_state      = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (rsp_ready[gid]) begin
          consume    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ~RR_FIRST;
      gid        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= ALU_AND;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        gid     <= pick;
        op_a    <= req_a[pick];
        op_b    <= req_b[pick];
        op_code <= alu_op_t'(req_op[pick]);
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= (alu_result == '0);
        rsp_valid  <= gid ? 2'b10 : 2'b01;
      end
      if (consume) begin
        rsp_valid  <= 2'b00;
        last_grant <= gid;
      end
    end
  end

  alu u_alu (
    .a          (op_a),
    .b          (op_b),
    .ALUControl (op_code),
    .ALUResult  (alu_result)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses on each
// request handshake, a monitor pops and compares on each response handshake.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [1:0][7:0] req_a = '0;
  logic [1:0][7:0] req_b = '0;
  logic [1:0][1:0] req_op = '0;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = 2'b11;
  logic [7:0]      rsp_result;
  logic            rsp_zero;
  logic            busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];

  always #5 clk = ~clk;

  alu_arbiter #(.RR_START(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Entered on a falling edge; returns on the falling edge after the handshake.
  task automatic applyStimulus(input logic id, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [7:0] exp_res,
                               input logic exp_zero, input bit expect_rsp);
    bit done = 0;
    req_a[id]     = a;
    req_b[id]     = b;
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (req_ready[id]) begin
        done = 1;
        grant_log.push_back(id);
        if (expect_rsp) sb.push_back('{id, exp_res, exp_zero});
      end
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout req%0d: got no grant, expected one within 50 cycles", id);
    end
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int c = 0; c < 50 && !idle; c++) begin
      @(negedge clk);
      #1;
      if (!busy && rsp_valid == 2'b00) idle = 1;
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: got busy=%0b rsp_valid=%02b, expected idle", busy, rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"},  {6'd0, req_ready}, 8'h00);
    checkOutput({tag, "_rsp_valid"},  {6'd0, rsp_valid}, 8'h00);
    checkOutput({tag, "_rsp_result"}, rsp_result,        8'h00);
    checkOutput({tag, "_rsp_zero"},   {7'd0, rsp_zero},  8'h00);
    checkOutput({tag, "_busy"},       {7'd0, busy},      8'h00);
  endtask

  // Monitor samples mid-low-phase, after drivers have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid != 2'b00) begin
        checkOutput("rsp_valid_onehot", {7'd0, $onehot(rsp_valid)}, 8'h01);
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=%02b result=0x%02h, expected no response",
                   rsp_valid, rsp_result);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_owner",  {6'd0, rsp_valid}, e.id ? 8'h02 : 8'h01);
          checkOutput("rsp_result", rsp_result,        e.res);
          checkOutput("rsp_zero",   {7'd0, rsp_zero},  {7'd0, e.zero});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_order[4] = '{0, 1, 0, 1};

    // Reset and idle values
    @(negedge clk);
    doReset();
    #1;
    checkResetValues("reset");
    @(negedge clk);

    // Single request latency
    applyStimulus(1'b0, 8'h05, 8'h03, ALU_ADD, 8'h08, 1'b0, 1'b1);
    #1;
    checkOutput("exec_rsp_valid", {6'd0, rsp_valid}, 8'h00);
    checkOutput("exec_busy",      {7'd0, busy},      8'h01);
    checkOutput("exec_req_ready", {6'd0, req_ready}, 8'h00);
    @(negedge clk);
    #1;
    checkOutput("t2_rsp_valid",  {6'd0, rsp_valid}, 8'h01);
    checkOutput("t2_rsp_result", rsp_result,        8'h08);
    @(negedge clk);
    #1;
    checkOutput("after_rsp_valid", {6'd0, rsp_valid}, 8'h00);
    checkOutput("after_rsp_busy",  {7'd0, busy},      8'h00);
    @(negedge clk);

    // Contention and round-robin order
    doReset();
    grant_log.delete();
    fork
      begin
        applyStimulus(1'b0, 8'h0F, 8'h3C, ALU_AND, 8'h0C, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h0F, 8'h3C, ALU_AND, 8'h0C, 1'b0, 1'b1);
      end
      begin
        applyStimulus(1'b1, 8'h02, 8'h01, ALU_SUB, 8'h01, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h02, 8'h01, ALU_SUB, 8'h01, 1'b0, 1'b1);
      end
    join
    waitIdle();
    checkOutput("grant_count", 8'(grant_log.size()), 8'h04);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) begin
        checkOutput($sformatf("grant_order%0d", i), {7'd0, grant_log[i]}, 8'(exp_order[i]));
      end
    end

    // Backpressure on requester 1 while requester 0 waits
    rsp_ready = 2'b01;
    applyStimulus(1'b1, 8'h07, 8'h00, ALU_OR, 8'h07, 1'b0, 1'b1);
    req_a[0]     = 8'h10;
    req_b[0]     = 8'h20;
    req_op[0]    = ALU_ADD;
    req_valid[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_rsp_valid",  {6'd0, rsp_valid}, 8'h02);
      checkOutput("bp_rsp_result", rsp_result,        8'h07);
      checkOutput("bp_req_ready",  {6'd0, req_ready}, 8'h00);
      @(negedge clk);
    end
    rsp_ready = 2'b11;
    #1;
    checkOutput("consume_cycle_req_ready", {6'd0, req_ready}, 8'h00);
    @(negedge clk);
    #1;
    checkOutput("post_bp_req_ready", {6'd0, req_ready}, 8'h01);
    sb.push_back('{1'b0, 8'h30, 1'b0});
    @(negedge clk);
    req_valid[0] = 1'b0;
    waitIdle();

    // Wraparound and zero flag
    applyStimulus(1'b0, 8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("wrap_zero_flag", {7'd0, rsp_zero}, 8'h01);
    waitIdle();
    applyStimulus(1'b1, 8'h00, 8'h01, ALU_SUB, 8'hFF, 1'b0, 1'b1);
    waitIdle();

    // Reset during EXEC
    applyStimulus(1'b0, 8'h01, 8'h01, ALU_ADD, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkResetValues("rst_exec");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h33, 8'h11, ALU_SUB, 8'h22, 1'b0, 1'b1);
    waitIdle();

    // Reset during RESP
    rsp_ready = 2'b00;
    applyStimulus(1'b0, 8'h0A, 8'h0B, ALU_OR, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("resp_before_reset", {6'd0, rsp_valid}, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkResetValues("rst_resp");
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 2'b11;
    applyStimulus(1'b0, 8'h0A, 8'h0B, ALU_OR, 8'h0B, 1'b0, 1'b1);
    waitIdle();

    checkOutput("scoreboard_empty", 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
